// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code receive path.
// Holds the tracker state encoding and the Gray-to-binary function.
package gray_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  // Zero-extended input decodes to the same low bits at any width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Pure combinational Gray-to-binary decoder.
// Shared by the receive tracker and the counter self-check.
module gray2bin_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] Gray,
  output logic [WIDTH-1:0] Bin
);

  logic [31:0] full;

  assign full = gray2bin(32'(Gray));
  assign Bin  = full[WIDTH-1:0];

endmodule

// File: rtl/gray_decoder.sv
// Receive end of the Gray counter link: decodes, tracks
// direction and wrap, and flags any non +/-1 step.
module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Valid,
  input  logic             Resync,
  input  logic [WIDTH-1:0] GrayIn,
  output logic [WIDTH-1:0] Binary,
  output logic             Locked,
  output logic             Step,
  output logic             Dir,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Error
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] TOP  = '1;

  state_t           state, state_n;
  logic [WIDTH-1:0] dec, up, dn, bin_n;
  logic             locked_n, step_n, dir_n;
  logic             ovf_n, unf_n, err_n;

  gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
    .Gray (GrayIn),
    .Bin  (dec)
  );

  assign up = Binary + ONE;
  assign dn = Binary - ONE;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ACQUIRE;
      Binary    <= '0;
      Locked    <= 1'b0;
      Step      <= 1'b0;
      Dir       <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Error     <= 1'b0;
    end else begin
      state     <= state_n;
      Binary    <= bin_n;
      Locked    <= locked_n;
      Step      <= step_n;
      Dir       <= dir_n;
      Overflow  <= ovf_n;
      Underflow <= unf_n;
      Error     <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    bin_n    = Binary;
    locked_n = Locked;
    step_n   = 1'b0;
    dir_n    = Dir;
    ovf_n    = Overflow;
    unf_n    = Underflow;
    err_n    = Error;
    if (Resync) begin
      state_n  = ACQUIRE;
      locked_n = 1'b0;
      ovf_n    = 1'b0;
      unf_n    = 1'b0;
      err_n    = 1'b0;
    end else if (Valid) begin
      unique case (state)
        ACQUIRE: begin
          bin_n    = dec;
          locked_n = 1'b1;
          state_n  = TRACK;
        end
        TRACK: begin
          // Legality is binary distance, not Hamming distance.
          unique case (1'b1)
            (dec == Binary): ;
            (dec == up): begin
              bin_n  = dec;
              step_n = 1'b1;
              dir_n  = 1'b1;
              if (Binary == TOP) ovf_n = 1'b1;
            end
            (dec == dn): begin
              bin_n  = dec;
              step_n = 1'b1;
              dir_n  = 1'b0;
              if (Binary == ZERO) unf_n = 1'b1;
            end
            default: begin
              err_n    = 1'b1;
              locked_n = 1'b0;
              state_n  = FAULT;
            end
          endcase
        end
        FAULT: ;
        default: state_n = ACQUIRE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_decoder.sv
// Directed self-checking bench for gray_decoder (WIDTH=3).
// Inputs change on the falling edge; outputs are sampled there too.
module tb_gray_decoder;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Valid;
  logic       Resync;
  logic [2:0] GrayIn;
  logic [2:0] Binary;
  logic       Locked, Step, Dir;
  logic       Overflow, Underflow, Error;

  int n_assert = 0;
  int n_fail   = 0;

  gray_decoder #(.WIDTH(3)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Valid     (Valid),
    .Resync    (Resync),
    .GrayIn    (GrayIn),
    .Binary    (Binary),
    .Locked    (Locked),
    .Step      (Step),
    .Dir       (Dir),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .Error     (Error)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; returns at the next falling edge.
  task automatic send(input logic v, input logic [2:0] g,
                      input logic rs);
    Valid  = v;
    GrayIn = g;
    Resync = rs;
    @(negedge Clk);
  endtask

  logic [2:0] up_g [8] = '{3'b001, 3'b011, 3'b010, 3'b110,
                           3'b111, 3'b101, 3'b100, 3'b000};
  logic [2:0] dn_g [3] = '{3'b100, 3'b101, 3'b111};
  int         dn_b [3] = '{7, 6, 5};

  initial begin
    Reset_n = 1'b0;
    Valid   = 1'b1;
    Resync  = 1'b0;
    GrayIn  = 3'b101;
    repeat (2) @(negedge Clk);
    check("rst_bin",  int'(Binary),    0);
    check("rst_lock", int'(Locked),    0);
    check("rst_step", int'(Step),      0);
    check("rst_dir",  int'(Dir),       0);
    check("rst_ovf",  int'(Overflow),  0);
    check("rst_unf",  int'(Underflow), 0);
    check("rst_err",  int'(Error),     0);

    Reset_n = 1'b1;
    send(1'b1, 3'b011, 1'b0);
    check("acq_bin",  int'(Binary), 2);
    check("acq_lock", int'(Locked), 1);
    check("acq_step", int'(Step),   0);

    send(1'b0, 3'b111, 1'b0);
    check("nv_bin",  int'(Binary), 2);
    check("nv_step", int'(Step),   0);

    // Full up count through the wrap
    send(1'b0, 3'b000, 1'b1);
    send(1'b1, 3'b000, 1'b0);
    check("up_acq", int'(Binary), 0);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, up_g[i], 1'b0);
      check("up_bin",  int'(Binary), (i + 1) % 8);
      check("up_step", int'(Step),   1);
      check("up_dir",  int'(Dir),    1);
      if (i == 6) check("up_ovf_pre", int'(Overflow), 0);
    end
    check("up_ovf", int'(Overflow), 1);
    check("up_err", int'(Error),    0);
    check("up_unf", int'(Underflow), 0);

    // Down count through the wrap
    send(1'b0, 3'b000, 1'b1);
    check("rs_ovf", int'(Overflow), 0);
    send(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, dn_g[i], 1'b0);
      check("dn_bin",  int'(Binary), dn_b[i]);
      check("dn_step", int'(Step),   1);
      check("dn_dir",  int'(Dir),    0);
    end
    check("dn_unf", int'(Underflow), 1);
    check("dn_ovf", int'(Overflow),  0);

    // One-bit Gray change that is not a +/-1 step
    send(1'b0, 3'b000, 1'b1);
    send(1'b1, 3'b001, 1'b0);
    check("ill_acq", int'(Binary), 1);
    send(1'b1, 3'b101, 1'b0);
    check("ill_err",  int'(Error),  1);
    check("ill_lock", int'(Locked), 0);
    check("ill_bin",  int'(Binary), 1);
    check("ill_step", int'(Step),   0);
    send(1'b1, 3'b011, 1'b0);
    check("flt_bin",  int'(Binary), 1);
    check("flt_step", int'(Step),   0);
    check("flt_err",  int'(Error),  1);

    // Resync wins over a simultaneous sample
    send(1'b1, 3'b110, 1'b1);
    check("rs_bin",  int'(Binary), 1);
    check("rs_lock", int'(Locked), 0);
    check("rs_err",  int'(Error),  0);
    send(1'b1, 3'b110, 1'b0);
    check("rq_bin",  int'(Binary), 4);
    check("rq_lock", int'(Locked), 1);
    check("rq_step", int'(Step),   0);

    send(1'b1, 3'b111, 1'b0);
    check("st_bin",  int'(Binary), 5);
    check("st_step", int'(Step),   1);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 3'b111, 1'b0);
      check("hold_bin",  int'(Binary), 5);
      check("hold_step", int'(Step),   0);
    end

    // Asynchronous reset between clock edges
    #2 Reset_n = 1'b0;
    #1;
    check("ar_bin",  int'(Binary), 0);
    check("ar_lock", int'(Locked), 0);
    check("ar_dir",  int'(Dir),    0);
    @(negedge Clk);
    Reset_n = 1'b1;
    send(1'b1, 3'b011, 1'b0);
    check("ar_acq_bin",  int'(Binary), 2);
    check("ar_acq_lock", int'(Locked), 1);
    check("ar_acq_err",  int'(Error),  0);
    check("ar_acq_step", int'(Step),   0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
